// File: rtl/clk_d_monitor.sv
// clk_d_monitor: measures the period and high time of clk_d, a same-domain divided clock sampled as
//   data, and runs a lock/fault state machine against an expected period and tolerance.
// Latency: period/high_time/meas_valid/locked are registered, 1 cycle after the rise-detect cycle.
// Backpressure: none; the monitor observes clk_d and never stalls it.
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   clk_d, en         - divided clock (sampled as data), monitor enable (0 forces IDLE)
//   exp_period, tol   - expected period and allowed absolute deviation, both in clk cycles
//   period, high_time - last measured period / high time
//   meas_valid        - 1-cycle pulse when period/high_time update
//   locked, lock_lost - LOCKED state indicator, 1-cycle pulse on LOCKED->ACQUIRE
//   fault             - clk_d stuck (no rise for TIMEOUT cycles); sticky until en=0 or rst
module clk_d_monitor #(
  parameter int CNT_W    = 16,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_d,
  input  logic             en,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [3:0]       tol,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             lock_lost,
  output logic             fault
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [MC_W-1:0]  MC_LAST   = MC_W'(LOCK_CNT - 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, FAULT} state_t;

  state_t           state_q, state_d;
  logic             d_q;
  logic [CNT_W-1:0] per_cnt_q, hi_hold_q;
  logic             armed_q, fall_seen_q;
  logic [MC_W-1:0]  match_cnt_q;
  logic [CNT_W-1:0] period_q, high_time_q;
  logic             meas_valid_q, lock_lost_q;

  logic               rise, fall, active, tracking, meas, timeout, in_tol, match_last;
  logic signed [CNT_W:0] diff;
  logic [CNT_W:0]     abs_diff;

  assign rise = clk_d & ~d_q;
  assign fall = ~clk_d & d_q;

  // Counters only run outside IDLE; en=0 takes priority and clears them on the same edge.
  assign active   = en && (state_q != IDLE);
  assign tracking = en && (state_q == ACQUIRE || state_q == LOCKED);

  // A measurement needs a prior rise (armed) and a fall since it, so the first rise is never measured.
  assign meas = tracking && rise && armed_q && fall_seen_q;

  // A rise in the timeout cycle wins: per_cnt reloads and no fault is raised.
  assign timeout = tracking && !rise && (per_cnt_q >= TIMEOUT_C);

  // Operands are zero-extended so the signed difference and its magnitude cannot overflow.
  assign diff     = $signed({1'b0, per_cnt_q}) - $signed({1'b0, exp_period});
  assign abs_diff = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
  assign in_tol   = abs_diff <= (CNT_W + 1)'(tol);
  assign match_last = (match_cnt_q == MC_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ACQUIRE;
        ACQUIRE: begin
          if (timeout)                         state_d = FAULT;
          else if (meas && in_tol && match_last) state_d = LOCKED;
        end
        LOCKED: begin
          if (timeout)             state_d = FAULT;
          else if (meas && !in_tol) state_d = ACQUIRE;
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
  end

  // State-derived outputs
  always_comb begin
    locked = (state_q == LOCKED);
    fault  = (state_q == FAULT);
  end

  // Measurement datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q          <= 1'b0;
      per_cnt_q    <= '0;
      hi_hold_q    <= '0;
      armed_q      <= 1'b0;
      fall_seen_q  <= 1'b0;
      match_cnt_q  <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      d_q          <= clk_d;
      meas_valid_q <= meas;
      lock_lost_q  <= (state_q == LOCKED) && (state_d == ACQUIRE);
      if (meas) begin
        period_q    <= per_cnt_q;
        high_time_q <= hi_hold_q;
      end
      if (!active) begin
        per_cnt_q   <= '0;
        hi_hold_q   <= '0;
        armed_q     <= 1'b0;
        fall_seen_q <= 1'b0;
        match_cnt_q <= '0;
      end else begin
        if (rise)                 per_cnt_q <= CNT_W'(1);
        else if (per_cnt_q != '1) per_cnt_q <= per_cnt_q + CNT_W'(1);
        if (fall) begin
          hi_hold_q   <= per_cnt_q;
          fall_seen_q <= 1'b1;
        end
        if (rise) begin
          armed_q     <= 1'b1;
          fall_seen_q <= 1'b0;
        end
        if (timeout)
          match_cnt_q <= '0;
        else if (meas && state_q == ACQUIRE)
          match_cnt_q <= in_tol ? match_cnt_q + MC_W'(1) : '0;
        else if (meas && state_q == LOCKED && !in_tol)
          match_cnt_q <= '0;
      end
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign lock_lost  = lock_lost_q;

endmodule
